wb_ldpc_master: RTL

WB_LDPC_MASTER -- requirements
Module: wb_ldpc_master

---
 rtl/wb_ldpc_master.sv | 89 ++++++++
 1 files changed

// File: rtl/wb_ldpc_master.sv
// wb_ldpc_master: in-order Wishbone master fed by a command FIFO; define WBM_TIMEOUT_EN to abort unacked cycles after TIMEOUT_CYC.
module wb_ldpc_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_we,
  input  logic [31:0]                   cmd_adr,
  input  logic [31:0]                   cmd_dat,
  input  logic [3:0]                    cmd_sel,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_dat,
  output logic                          rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wbm_cyc_o,
  output logic                          wbm_stb_o,
  output logic                          wbm_we_o,
  output logic [3:0]                    wbm_sel_o,
  output logic [31:0]                   wbm_adr_o,
  output logic [31:0]                   wbm_dat_o,
  input  logic                          wbm_ack_i,
  input  logic [31:0]                   wbm_dat_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;
  state_t state, state_d;
  logic [68:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic push, pop, done, tmo;
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("wb_ldpc_master: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC in 1..65535");
  end
  // Pointers carry a wrap bit, so the level MSB alone flags a full FIFO.
  assign fifo_level = wptr - rptr;
  assign cmd_ready = !wb_rst_i && !fifo_level[AW];
  assign push = cmd_valid && cmd_ready;
`ifdef WBM_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  assign tmo = state == BUS && !wbm_ack_i && tmo_cnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge wb_clk_i)
    tmo_cnt <= (wb_rst_i || state != BUS) ? '0 : tmo_cnt + 16'd1;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    pop = state == IDLE && wptr != rptr;
    done = state == BUS && (wbm_ack_i || tmo);
    state_d = pop ? BUS : done ? RSP : (state == RSP && rsp_ready) ? IDLE : state;
  end
  always_ff @(posedge wb_clk_i)
    state <= wb_rst_i ? IDLE : state_d;
  always_ff @(posedge wb_clk_i)
    if (push) mem[wptr[AW-1:0]] <= {cmd_we, cmd_sel, cmd_adr, cmd_dat};
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wptr <= '0;
      rptr <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} <= mem[rptr[AW-1:0]];
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
      end
      if (done) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_dat <= tmo ? 32'hDEAD_BEEF : wbm_we_o ? '0 : wbm_dat_i;
        rsp_err <= tmo;
      end
      if (state == RSP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule
